// File: rtl/mem_pkg.sv
// Shared memory-access definitions used by the load/store unit and the data memory.
package mem_pkg;

    // Access width; encoding 2'b11 is unused and rejected by the load/store unit.
    typedef enum logic [1:0] {
        RW_B    = 2'b00,
        RW_HALF = 2'b01,
        RW_WORD = 2'b10
    } rw_type;

    // Number of bytes touched by an access of the given width (unused encoding treated as a word).
    function automatic logic [2:0] rw_size(input logic [1:0] t);
        case (t)
            2'b00:   rw_size = 3'd1;
            2'b01:   rw_size = 3'd2;
            default: rw_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Zero/sign extension of load data assembled from individual byte reads.
module lsu_extend
    import mem_pkg::*;
(
    input  logic [31:0] raw_data,
    input  rw_type      acc_type,
    input  logic        sign_ext,
    output logic [31:0] ext_data
);

    // Fill the bits above the access width with zero or with the access's top bit.
    always_comb begin
        ext_data = raw_data;
        case (acc_type)
            RW_B:    ext_data = {{24{sign_ext & raw_data[7]}}, raw_data[7:0]};
            RW_HALF: ext_data = {{16{sign_ext & raw_data[15]}}, raw_data[15:0]};
            default: ext_data = raw_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, aligned accesses in a single memory
// cycle, misaligned half/word accesses split into consecutive byte accesses.
module load_store_unit
    import mem_pkg::*;
#(
    parameter logic [31:0] MEM_SIZE = 32'h20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  rw_type      req_type,
    input  logic        req_sign_ext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_write_en,
    output rw_type      mem_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_sign_ext,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        SPLIT  = 2'b10,
        RESP   = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    rw_type      type_q, type_d;
    logic        sign_ext_q, sign_ext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    // Request classification, done on the live request while idle.
    logic [1:0]  req_type_bits;
    logic [2:0]  req_size;
    logic [32:0] req_end;
    logic        req_bad;
    logic        req_misaligned;

    assign req_type_bits  = req_type;
    assign req_size       = rw_size(req_type_bits);
    // 33-bit end address so that a wrap past 2^32 is seen as out of range.
    assign req_end        = {1'b0, req_addr} + {30'd0, req_size} - 33'd1;
    assign req_bad        = (req_type_bits == 2'b11) || (req_end >= {1'b0, MEM_SIZE});
    assign req_misaligned = ((req_type == RW_HALF) && req_addr[0]) ||
                            ((req_type == RW_WORD) && (req_addr[1:0] != 2'b00));

    // Last byte of a split access: byte 1 for a half, byte 3 for a word.
    logic        split_last;
    logic [31:0] split_data;
    logic [31:0] ext_data;

    assign split_last = (type_q == RW_HALF) ? (cnt_q == 2'd1) : (cnt_q == 2'd3);

    // Merge the byte returned this cycle into its lane of the partial load result.
    always_comb begin
        split_data = rsp_rdata_q;
        split_data[{cnt_q, 3'b000} +: 8] = mem_dout[7:0];
    end

    lsu_extend u_extend (
        .raw_data (split_data),
        .acc_type (type_q),
        .sign_ext (sign_ext_q),
        .ext_data (ext_data)
    );

    // Memory-side drive decoded purely from registered state, idle values elsewhere.
    always_comb begin
        mem_write_en = 1'b0;
        mem_type     = RW_WORD;
        mem_addr     = 32'd0;
        mem_din      = 32'd0;
        mem_sign_ext = 1'b0;
        case (state_q)
            ACCESS: begin
                mem_write_en = write_q;
                mem_type     = type_q;
                mem_addr     = addr_q;
                mem_din      = wdata_q;
                mem_sign_ext = sign_ext_q;
            end
            SPLIT: begin
                mem_write_en = write_q;
                mem_type     = RW_B;
                mem_addr     = addr_q + {30'd0, cnt_q};
                mem_din      = {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
            end
            default: ;
        endcase
    end

    // Next-state and register-update logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        type_d      = type_q;
        sign_ext_d  = sign_ext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d     = req_write;
                    type_d      = req_type;
                    sign_ext_d  = req_sign_ext;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    cnt_d       = 2'd0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    if (req_bad) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else if (req_misaligned) begin
                        state_d = SPLIT;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    rsp_rdata_d = mem_dout;
                end
                state_d = RESP;
            end
            SPLIT: begin
                if (!write_q) begin
                    rsp_rdata_d = split_last ? ext_data : split_data;
                end
                if (split_last) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                rsp_rdata_d = 32'd0;
                rsp_err_d   = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            write_q     <= 1'b0;
            type_q      <= RW_B;
            sign_ext_q  <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            type_q      <= type_d;
            sign_ext_q  <= sign_ext_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data memory, transaction-level model,
// per-cycle compare of handshake/memory/response outputs plus literal checks.
module tb_load_store_unit;
    import mem_pkg::*;

    localparam logic [31:0] MSZ = 32'h20000;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    rw_type      req_type;
    logic        req_sign_ext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_write_en;
    rw_type      mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_sign_ext;
    logic [31:0] mem_dout;

    load_store_unit #(.MEM_SIZE(MSZ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_type     (req_type),
        .req_sign_ext (req_sign_ext),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_write_en (mem_write_en),
        .mem_type     (mem_type),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_sign_ext (mem_sign_ext),
        .mem_dout     (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- data memory seen by the DUT ----------------
    logic [7:0]  mem_arr [0:131071];
    logic [16:0] a0, a1, a2, a3;
    logic [7:0]  b0, b1, b2, b3;
    assign a0 = mem_addr[16:0];
    assign a1 = a0 + 17'd1;
    assign a2 = a0 + 17'd2;
    assign a3 = a0 + 17'd3;
    assign b0 = mem_arr[a0];
    assign b1 = mem_arr[a1];
    assign b2 = mem_arr[a2];
    assign b3 = mem_arr[a3];
    assign mem_dout = (mem_type == RW_B)    ? {{24{mem_sign_ext & b0[7]}}, b0} :
                      (mem_type == RW_HALF) ? {{16{mem_sign_ext & b1[7]}}, b1, b0} :
                                              {b3, b2, b1, b0};

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem_arr[a0] <= mem_din[7:0];
            if (mem_type != RW_B) mem_arr[a1] <= mem_din[15:8];
            if (mem_type == RW_WORD) begin
                mem_arr[a2] <= mem_din[23:16];
                mem_arr[a3] <= mem_din[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:131071];

    typedef struct {
        int          due;
        int          acc;
        bit          wr;
        logic [1:0]  typ;
        bit          sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
    } txn_t;
    txn_t q[$];

    int acc_cyc = -100;
    int acc_lat = 0;
    bit acc_wr  = 0;
    bit acc_err = 0;
    bit chk_en  = 0;

    int n_pass  = 0;
    int n_total = 0;
    int resp_count = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    function automatic int nbytes(input logic [1:0] t);
        return (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_err(input logic [1:0] t, input logic [31:0] a);
        longint last_byte;
        last_byte = longint'({32'd0, a}) + longint'(nbytes(t)) - 1;
        return (t == 2'b11) || (last_byte >= longint'({32'd0, MSZ}));
    endfunction

    function automatic int latency(input logic [1:0] t, input logic [31:0] a);
        if (is_err(t, a)) return 1;
        if ((t == 2'b01 && a[0]) || (t == 2'b10 && a[1:0] != 2'b00)) return nbytes(t) + 1;
        return 2;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] t, input bit sx, input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = nbytes(t);
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[17'(a + 32'(k))];
        if (n < 4 && sx && v[8*n-1]) begin
            for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && rst_n) begin
                bit busy, work;
                busy = (cyc > acc_cyc) && (cyc <= acc_cyc + acc_lat);
                work = (cyc > acc_cyc) && (cyc < acc_cyc + acc_lat) && !acc_err;
                check("req_ready", 32'(req_ready), 32'(!busy));
                check("mem_write_en", 32'(mem_write_en), 32'(work && acc_wr));
                if (!work) begin
                    check("mem_idle", {mem_addr | mem_din, 30'd0, mem_type}, {32'd0, 30'd0, RW_WORD});
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    txn_t t;
                    logic [31:0] exp_d;
                    t = q.pop_front();
                    exp_d = 32'd0;
                    if (!t.err) begin
                        if (t.wr) begin
                            for (int k = 0; k < nbytes(t.typ); k++)
                                ref_mem[17'(t.addr + 32'(k))] = t.wdata[8*k +: 8];
                        end else begin
                            exp_d = model_load(t.typ, t.sx, t.addr);
                        end
                    end
                    check("rsp_valid", 32'(rsp_valid), 32'd1);
                    check("rsp_rdata", rsp_rdata, exp_d);
                    check("rsp_err", 32'(rsp_err), 32'(t.err));
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                    last_lat   = cyc - t.acc;
                    resp_count++;
                end else begin
                    check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input bit wr, input logic [1:0] t, input bit sx, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold, input bit wait_rsp);
        int n;
        int target;
        txn_t e;
        req_write    = wr;
        req_type     = rw_type'(t);
        req_sign_ext = sx;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("accept", 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        acc_lat = latency(t, a);
        acc_wr  = wr;
        acc_err = is_err(t, a);
        e.due = cyc + acc_lat; e.acc = cyc; e.wr = wr; e.typ = t; e.sx = sx;
        e.addr = a; e.wdata = wd; e.err = acc_err;
        q.push_back(e);
        target = resp_count + 1;
        @(posedge clk); #1;
        if (hold) begin
            req_addr     = ~a;
            req_wdata    = ~wd;
            req_write    = ~wr;
            req_sign_ext = ~sx;
        end else begin
            req_valid = 1'b0;
        end
        if (wait_rsp) begin
            n = 0;
            while (resp_count < target && n < 40) begin
                @(negedge clk); #1;
                n++;
            end
            check("rsp_seen", 32'(resp_count), 32'(target));
        end
    endtask

    task automatic expect_last(input string name, input logic [31:0] d, input bit e, input int lat);
        check({name, "_rdata"}, last_rdata, d);
        check({name, "_err"}, 32'(last_err), 32'(e));
        check({name, "_lat"}, 32'(last_lat), 32'(lat));
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) begin
            mem_arr[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_type = RW_WORD;
        req_sign_ext = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mem_we", 32'(mem_write_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        chk_en = 1'b1;

        // aligned word store then load
        do_req(1, 2'b10, 0, 32'h10000, 32'hDEADBEEF, 0, 1);
        expect_last("st_word", 32'd0, 0, 2);
        do_req(0, 2'b10, 0, 32'h10000, 32'h0, 0, 1);
        expect_last("ld_word", 32'hDEADBEEF, 0, 2);

        // misaligned word store, byte placement, load back
        do_req(1, 2'b10, 0, 32'h10001, 32'h11223344, 0, 1);
        expect_last("st_mis_word", 32'd0, 0, 5);
        check("byte_10001", 32'(mem_arr[17'h10001]), 32'h44);
        check("byte_10002", 32'(mem_arr[17'h10002]), 32'h33);
        check("byte_10003", 32'(mem_arr[17'h10003]), 32'h22);
        check("byte_10004", 32'(mem_arr[17'h10004]), 32'h11);
        do_req(0, 2'b10, 0, 32'h10001, 32'h0, 0, 1);
        expect_last("ld_mis_word", 32'h11223344, 0, 5);

        // misaligned half loads with and without sign extension
        do_req(1, 2'b00, 0, 32'h10005, 32'h80, 0, 1);
        do_req(1, 2'b00, 0, 32'h10006, 32'h80, 0, 1);
        do_req(0, 2'b01, 1, 32'h10005, 32'h0, 0, 1);
        expect_last("ld_mis_half_sx", 32'hFFFF8080, 0, 3);
        do_req(0, 2'b01, 0, 32'h10005, 32'h0, 0, 1);
        expect_last("ld_mis_half_zx", 32'h00008080, 0, 3);

        // aligned narrow loads rely on the memory's extension
        do_req(0, 2'b01, 1, 32'h10004, 32'h0, 0, 1);
        expect_last("ld_half_sx", 32'hFFFF8011, 0, 2);
        do_req(0, 2'b00, 1, 32'h10006, 32'h0, 0, 1);
        expect_last("ld_byte_sx", 32'hFFFFFF80, 0, 2);
        do_req(1, 2'b01, 0, 32'h10007, 32'h1234BEEF, 0, 1);
        expect_last("st_mis_half", 32'd0, 0, 3);
        do_req(0, 2'b10, 0, 32'h10005, 32'h0, 0, 1);
        expect_last("ld_mis_word2", 32'hBEEF8080, 0, 5);

        // range and type errors, plus in-range boundary accesses
        do_req(0, 2'b10, 0, MSZ - 32'd2, 32'h0, 0, 1);
        expect_last("err_word_top", 32'd0, 1, 1);
        do_req(1, 2'b11, 0, 32'h100, 32'hFFFFFFFF, 0, 1);
        expect_last("err_type", 32'd0, 1, 1);
        do_req(1, 2'b10, 0, 32'hFFFFFFFE, 32'h55555555, 0, 1);
        expect_last("err_wrap", 32'd0, 1, 1);
        do_req(1, 2'b01, 0, MSZ - 32'd1, 32'hAAAA, 0, 1);
        expect_last("err_half_top", 32'd0, 1, 1);
        do_req(0, 2'b00, 0, MSZ - 32'd1, 32'h0, 0, 1);
        expect_last("ld_byte_top", 32'd0, 0, 2);
        do_req(0, 2'b10, 0, MSZ - 32'd4, 32'h0, 0, 1);
        expect_last("ld_word_top", 32'd0, 0, 2);

        // request valid held high with changing fields while busy
        do_req(1, 2'b10, 0, 32'h200, 32'h0BADF00D, 1, 1);
        do_req(0, 2'b10, 0, 32'h202, 32'h0, 1, 1);
        expect_last("hold_ld_word", 32'h00000BAD, 0, 5);
        do_req(0, 2'b01, 1, 32'h201, 32'h0, 0, 1);
        expect_last("hold_ld_half", 32'hFFFFADF0, 0, 3);

        // reset during the second byte of a misaligned store
        do_req(1, 2'b10, 0, 32'h101, 32'hAABBCCDD, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", 32'(mem_write_en), 32'd0);
        check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        q.delete();
        acc_cyc = -100;
        ref_mem[17'h101] = 8'hDD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check("rst_hold_rsp", 32'(rsp_valid), 32'd0);
            check("rst_hold_we", 32'(mem_write_en), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_rel_ready", 32'(req_ready), 32'd1);
        check("rst_rel_byte0", 32'(mem_arr[17'h101]), 32'hDD);
        check("rst_rel_byte1", 32'(mem_arr[17'h102]), 32'h00);
        do_req(0, 2'b10, 0, 32'h101, 32'h0, 0, 1);
        expect_last("ld_after_rst", 32'h000000DD, 0, 5);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
